dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
`default_nettype none

package dmem_arb_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int MASTER_CORE = 0;
  localparam int MASTER_DBG  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage : dmem_arb_pkg

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// Two-master single-port data-memory arbiter with bounded bursts,
// round-robin tie-break and one-cycle load response routing.
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    req,
  input  logic [NUM_MASTERS-1:0]    we,
  input  logic [NUM_MASTERS*AW-1:0] addr,
  input  logic [NUM_MASTERS*DW-1:0] wdata,
  output logic [NUM_MASTERS-1:0]    gnt,
  output logic [NUM_MASTERS-1:0]    rvalid,
  output logic [DW-1:0]             rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_wdata,
  input  logic [DW-1:0]             mem_rdata
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  arb_state_e                 state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       rr_last_q, rr_last_d;
  logic [NUM_MASTERS-1:0]     rvalid_q, rvalid_d;
  logic [NUM_MASTERS-1:0]     grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_last_q <= 1'b1;
      rvalid_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Grant decision; the reset term keeps every memory-side output quiet in reset.
  always_comb begin
    grant = '0;
    unique case (state_q)
      IDLE: begin
        if (req[MASTER_CORE] && req[MASTER_DBG]) grant[~rr_last_q] = 1'b1;
        else                                      grant = req;
      end
      OWN0: begin
        if (req[MASTER_CORE] && (cnt_q < MAX_CNT || !req[MASTER_DBG])) grant[MASTER_CORE] = 1'b1;
        else if (req[MASTER_DBG])                                       grant[MASTER_DBG]  = 1'b1;
      end
      OWN1: begin
        if (req[MASTER_DBG] && (cnt_q < MAX_CNT || !req[MASTER_CORE])) grant[MASTER_DBG]  = 1'b1;
        else if (req[MASTER_CORE])                                      grant[MASTER_CORE] = 1'b1;
      end
      default: grant = '0;
    endcase
    if (!rst) grant = '0;
  end

  always_comb begin
    state_d   = IDLE;
    cnt_d     = '0;
    rr_last_d = rr_last_q;
    rvalid_d  = grant & ~we;
    if (|grant) begin
      rr_last_d = grant[MASTER_DBG];
      state_d   = grant[MASTER_DBG] ? OWN1 : OWN0;
      if (state_d == state_q) cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
      else                    cnt_d = CW'(1);
    end
  end

  always_comb begin
    gnt       = grant;
    mem_en    = |grant;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant[MASTER_DBG]) begin
      mem_we    = we[MASTER_DBG];
      mem_addr  = addr[2*AW-1:AW];
      mem_wdata = wdata[2*DW-1:DW];
    end else if (grant[MASTER_CORE]) begin
      mem_we    = we[MASTER_CORE];
      mem_addr  = addr[AW-1:0];
      mem_wdata = wdata[DW-1:0];
    end
    rvalid = rvalid_q;
    rdata  = (|rvalid_q) ? mem_rdata : '0;
  end

endmodule : dmem_arbiter

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level model.
`default_nettype none

module tb_dmem_arbiter;

  localparam int MAX_BURST = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, we;
  logic [63:0]   addr, wdata;
  logic [1:0]    gnt, rvalid;
  logic [31:0]   rdata, mem_addr, mem_wdata;
  logic          mem_en, mem_we;
  logic [31:0]   mem_rdata = '0;

  dmem_arbiter #(.MAX_BURST(MAX_BURST), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + i;
  endfunction

  // Environment memory: reads return one cycle later, junk otherwise.
  logic [31:0] env_mem [16];
  always @(posedge clk) begin
    if (mem_en && mem_we) env_mem[mem_addr[5:2]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= env_mem[mem_addr[5:2]];
    else                   mem_rdata <= $urandom;
  end

  // Reference model state
  logic [31:0] ref_mem [16];
  int          m_owner, m_beats, m_last;
  logic [1:0]  exp_rv;
  logic [31:0] exp_rd;
  int          wait_cyc [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  obs_gnt, obs_rv;
  logic [31:0] obs_rd, obs_addr, obs_wd;
  logic        obs_en, obs_we;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] r);
    if (m_owner >= 0) begin
      if (r[m_owner] && (m_beats < MAX_BURST || !r[1-m_owner])) return m_owner;
      if (r[1-m_owner]) return 1 - m_owner;
      return -1;
    end
    if (r == 2'b11) return 1 - m_last;
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_last = 1;
    exp_rv = '0; exp_rd = '0;
    wait_cyc[0] = 0; wait_cyc[1] = 0;
  endtask

  task automatic step(input logic [1:0] r, input logic [1:0] w,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    int g;
    logic [1:0] eg;
    logic [31:0] ga, gd;
    req = r; we = w; addr = {a1, a0}; wdata = {d1, d0};
    @(negedge clk);
    g  = pick(r);
    eg = (g < 0) ? 2'b00 : 2'(1 << g);
    ga = (g == 1) ? a1 : (g == 0) ? a0 : 32'h0;
    gd = (g == 1) ? d1 : (g == 0) ? d0 : 32'h0;
    obs_gnt = gnt; obs_rv = rvalid; obs_rd = rdata;
    obs_en = mem_en; obs_we = mem_we; obs_addr = mem_addr; obs_wd = mem_wdata;
    check("gnt", gnt, eg);
    check("onehot", $onehot0(gnt), 1);
    check("mem", {mem_en, mem_we, mem_addr, mem_wdata},
          {(g >= 0), (g >= 0) && w[g & 1], ga, gd});
    check("rvalid", rvalid, exp_rv);
    check("rdata", rdata, (exp_rv != 0) ? exp_rd : 32'h0);
    for (int j = 0; j < 2; j++) begin
      if (r[j] && !gnt[j]) wait_cyc[j]++;
      else wait_cyc[j] = 0;
      if (r[j]) check("starve", wait_cyc[j] <= MAX_BURST, 1);
    end
    @(posedge clk);
    exp_rv = '0;
    if (g < 0) begin
      m_owner = -1; m_beats = 0;
    end else begin
      if (g == m_owner) m_beats = (m_beats < MAX_BURST) ? m_beats + 1 : m_beats;
      else begin m_owner = g; m_beats = 1; end
      m_last = g;
      if (w[g]) ref_mem[ga[5:2]] = gd;
      else begin exp_rv = 2'(1 << g); exp_rd = ref_mem[ga[5:2]]; end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0; req = 2'b11; we = 2'b00;
    model_reset();
    repeat (n) begin
      @(negedge clk);
      check("rst_out", {gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata}, '0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
  endtask

  initial begin
    logic [1:0] r, w;
    rst = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    do_reset(3);

    // Tie after reset goes to master 0, load returns next cycle.
    step(2'b11, 2'b00, 32'h0, 32'h4, 0, 0);
    check("b34_gnt", obs_gnt, 2'b01);
    step(2'b00, 2'b00, 0, 0, 0, 0);
    check("b34_rv", obs_rv, 2'b01);
    check("b34_rd", obs_rd, init_word(0));

    // Burst limit: master 0 keeps 4 beats, then master 1 takes over.
    for (int c = 0; c < 10; c++) begin
      step({c >= 1, 1'b1}, 2'b00, 32'h0, 32'h4, 0, 0);
      if (c < 8) check("b35_gnt", obs_gnt, (c < 4) ? 2'b01 : 2'b10);
    end
    step(2'b00, 2'b00, 0, 0, 0, 0);

    // Lone debug store.
    step(2'b10, 2'b10, 32'h0, 32'h10, 0, 32'hDEADBEEF);
    check("b36_mem", {obs_en, obs_we, obs_addr, obs_wd}, {1'b1, 1'b1, 32'h10, 32'hDEADBEEF});
    step(2'b00, 2'b00, 0, 0, 0, 0);
    check("b36_rv", obs_rv, 2'b00);

    // Alternating single loads, no response bubble.
    for (int k = 0; k < 5; k++) begin
      r = (k == 4) ? 2'b00 : ((k % 2) ? 2'b10 : 2'b01);
      step(r, 2'b00, 32'h0, 32'h4, 0, 0);
      if (k < 4) check("b37_gnt", obs_gnt, r);
      if (k > 0) begin
        check("b37_rv", obs_rv, ((k - 1) % 2) ? 2'b10 : 2'b01);
        check("b37_rd", obs_rd, init_word((k - 1) % 2));
      end
    end

    // Reset right after a granted load drops the response.
    step(2'b01, 2'b00, 32'h8, 0, 0, 0);
    check("b38_gnt", obs_gnt, 2'b01);
    do_reset(2);
    step(2'b00, 2'b00, 0, 0, 0, 0);
    check("b38_rv", obs_rv, 2'b00);

    // Randomized traffic with sticky requests to provoke bursts.
    r = 2'b00;
    for (int n = 0; n < 10000; n++) begin
      for (int j = 0; j < 2; j++)
        if ($urandom_range(0, 9) < 3) r[j] = ~r[j];
      w = 2'($urandom);
      step(r, w, $urandom & 32'h3C, $urandom & 32'h3C, $urandom, $urandom);
    end
    step(2'b00, 2'b00, 0, 0, 0, 0);
    step(2'b00, 2'b00, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dmem_arbiter

`default_nettype wire
